qenc_mvd_binarizer: RTL and testbench

QENC_MVD_BINARIZER -- requirements
Module: qenc_mvd_binarizer

---
 rtl/qenc_mvd_binarizer.sv | 249 ++++++++++++++++++++++++
 tb/tb_qenc_mvd_binarizer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/qenc_mvd_binarizer.sv
`default_nettype none
// ============================================================================
// Module   : qenc_mvd_binarizer
// Function : Binarizes an (x,y) motion-vector difference into GT0/GT1 context
//            bins, EG1 remainder bypass bins and sign bypass bins.
// Revision : 1.0 - initial release
// ============================================================================
module qenc_mvd_binarizer #(
    parameter logic [9:0] CTX_ABS_MVD_GT0 = 10'd40,
    parameter logic [9:0] CTX_ABS_MVD_GT1 = 10'd41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mvd_start,
    input  logic [15:0] mvd_x,
    input  logic [15:0] mvd_y,
    output logic        busy,
    output logic        bin,
    output logic        bin_vld,
    input  logic        enc_rdy,
    output logic [9:0]  ctx_addr,
    output logic        EPMode,
    output logic        mvd_enc_done
);

    // Encoding order equals emission order, so "next state" is always +1.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GT0_0    = 4'd1,
        GT0_1    = 4'd2,
        GT1_0    = 4'd3,
        GT1_1    = 4'd4,
        MINUS2_0 = 4'd5,
        SIGN_0   = 4'd6,
        MINUS2_1 = 4'd7,
        SIGN_1   = 4'd8,
        DONE     = 4'd9
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [16:0] r_absx, r_absy, w_absx_nxt, w_absy_nxt;
    logic        r_negx, r_negy, w_negx_nxt, w_negy_nxt;
    logic [16:0] r_v, w_v_nxt;
    logic [4:0]  r_k, w_k_nxt;
    logic        r_suffix, w_suffix_nxt;
    logic [4:0]  r_idx, w_idx_nxt;

    logic        r_bin, r_bin_vld, r_ep, r_busy, r_done;
    logic [9:0]  r_ctx;
    logic        w_bin_d, w_vld_d, w_ep_d;
    logic [9:0]  w_ctx_d;

    logic        w_xfer;
    logic [16:0] w_absx_in, w_absy_in;
    logic [17:0] w_pow, w_pow_nxt;
    logic        w_v_ge;

    function automatic logic eligible(input state_t s, input logic [16:0] ax,
                                      input logic [16:0] ay);
        logic e;
        case (s)
            GT1_0, SIGN_0:    e = (ax != 17'd0);
            GT1_1, SIGN_1:    e = (ay != 17'd0);
            MINUS2_0:         e = (ax > 17'd1);
            MINUS2_1:         e = (ay > 17'd1);
            default:          e = 1'b1;
        endcase
        return e;
    endfunction

    // First state at or after s that actually emits a bin (DONE always qualifies).
    function automatic state_t first_from(input state_t s, input logic [16:0] ax,
                                          input logic [16:0] ay);
        state_t r;
        logic   found;
        r     = s;
        found = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (!found) begin
                if (eligible(r, ax, ay)) found = 1'b1;
                else                     r = state_t'(r + 4'd1);
            end
        end
        return r;
    endfunction

    // 17-bit magnitude so that -32768 maps to +32768.
    assign w_absx_in = mvd_x[15] ? (17'd0 - {1'b1, mvd_x}) : {1'b0, mvd_x};
    assign w_absy_in = mvd_y[15] ? (17'd0 - {1'b1, mvd_y}) : {1'b0, mvd_y};

    assign w_xfer    = r_bin_vld & enc_rdy;
    assign w_pow     = 18'd1 << r_k;
    assign w_v_ge    = ({1'b0, r_v} >= w_pow);
    assign w_pow_nxt = 18'd1 << w_k_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_absx_nxt   = r_absx;
        w_absy_nxt   = r_absy;
        w_negx_nxt   = r_negx;
        w_negy_nxt   = r_negy;
        w_v_nxt      = r_v;
        w_k_nxt      = r_k;
        w_suffix_nxt = r_suffix;
        w_idx_nxt    = r_idx;
        case (r_state)
            IDLE: begin
                if (mvd_start) begin
                    w_absx_nxt  = w_absx_in;
                    w_absy_nxt  = w_absy_in;
                    w_negx_nxt  = mvd_x[15];
                    w_negy_nxt  = mvd_y[15];
                    w_state_nxt = GT0_0;
                end
            end
            GT0_0:  if (w_xfer) w_state_nxt = GT0_1;
            GT0_1:  if (w_xfer) w_state_nxt = first_from(GT1_0, r_absx, r_absy);
            GT1_0:  if (w_xfer) w_state_nxt = first_from(GT1_1, r_absx, r_absy);
            GT1_1:  if (w_xfer) w_state_nxt = first_from(MINUS2_0, r_absx, r_absy);
            MINUS2_0, MINUS2_1: begin
                if (w_xfer) begin
                    if (!r_suffix) begin
                        if (w_v_ge) begin
                            w_v_nxt = r_v - w_pow[16:0];
                            w_k_nxt = r_k + 5'd1;
                        end else begin
                            w_suffix_nxt = 1'b1;
                            w_idx_nxt    = r_k - 5'd1;
                        end
                    end else if (r_idx == 5'd0) begin
                        w_state_nxt = first_from((r_state == MINUS2_0) ? SIGN_0 : SIGN_1,
                                                 r_absx, r_absy);
                    end else begin
                        w_idx_nxt = r_idx - 5'd1;
                    end
                end
            end
            SIGN_0: if (w_xfer) w_state_nxt = first_from(MINUS2_1, r_absx, r_absy);
            SIGN_1: if (w_xfer) w_state_nxt = DONE;
            DONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Fresh EG1 run on entry to a remainder state.
        if (w_state_nxt == MINUS2_0 && r_state != MINUS2_0) begin
            w_v_nxt      = r_absx - 17'd2;
            w_k_nxt      = 5'd1;
            w_suffix_nxt = 1'b0;
            w_idx_nxt    = 5'd0;
        end else if (w_state_nxt == MINUS2_1 && r_state != MINUS2_1) begin
            w_v_nxt      = r_absy - 17'd2;
            w_k_nxt      = 5'd1;
            w_suffix_nxt = 1'b0;
            w_idx_nxt    = 5'd0;
        end
    end

    // Output values are derived from next-state data so the ports stay registered.
    always_comb begin
        w_bin_d = 1'b0;
        w_vld_d = 1'b0;
        w_ep_d  = 1'b0;
        w_ctx_d = 10'd0;
        case (w_state_nxt)
            GT0_0: begin
                w_vld_d = 1'b1;
                w_bin_d = (w_absx_nxt != 17'd0);
                w_ctx_d = CTX_ABS_MVD_GT0;
            end
            GT0_1: begin
                w_vld_d = 1'b1;
                w_bin_d = (w_absy_nxt != 17'd0);
                w_ctx_d = CTX_ABS_MVD_GT0;
            end
            GT1_0: begin
                w_vld_d = 1'b1;
                w_bin_d = (w_absx_nxt > 17'd1);
                w_ctx_d = CTX_ABS_MVD_GT1;
            end
            GT1_1: begin
                w_vld_d = 1'b1;
                w_bin_d = (w_absy_nxt > 17'd1);
                w_ctx_d = CTX_ABS_MVD_GT1;
            end
            MINUS2_0, MINUS2_1: begin
                w_vld_d = 1'b1;
                w_ep_d  = 1'b1;
                w_bin_d = w_suffix_nxt ? w_v_nxt[w_idx_nxt]
                                       : ({1'b0, w_v_nxt} >= w_pow_nxt);
            end
            SIGN_0: begin
                w_vld_d = 1'b1;
                w_ep_d  = 1'b1;
                w_bin_d = w_negx_nxt;
            end
            SIGN_1: begin
                w_vld_d = 1'b1;
                w_ep_d  = 1'b1;
                w_bin_d = w_negy_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_absx    <= 17'd0;
            r_absy    <= 17'd0;
            r_negx    <= 1'b0;
            r_negy    <= 1'b0;
            r_v       <= 17'd0;
            r_k       <= 5'd0;
            r_suffix  <= 1'b0;
            r_idx     <= 5'd0;
            r_bin     <= 1'b0;
            r_bin_vld <= 1'b0;
            r_ep      <= 1'b0;
            r_ctx     <= 10'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_absx    <= w_absx_nxt;
            r_absy    <= w_absy_nxt;
            r_negx    <= w_negx_nxt;
            r_negy    <= w_negy_nxt;
            r_v       <= w_v_nxt;
            r_k       <= w_k_nxt;
            r_suffix  <= w_suffix_nxt;
            r_idx     <= w_idx_nxt;
            r_bin     <= w_bin_d;
            r_bin_vld <= w_vld_d;
            r_ep      <= w_ep_d;
            r_ctx     <= w_ctx_d;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= (w_state_nxt == DONE);
        end
    end

    assign busy         = r_busy;
    assign bin          = r_bin;
    assign bin_vld      = r_bin_vld;
    assign ctx_addr     = r_ctx;
    assign EPMode       = r_ep;
    assign mvd_enc_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_qenc_mvd_binarizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qenc_mvd_binarizer
// Function : Directed vector bench for qenc_mvd_binarizer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qenc_mvd_binarizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mvd_start;
    logic [15:0] mvd_x, mvd_y;
    logic        busy, bin, bin_vld, enc_rdy, EPMode, mvd_enc_done;
    logic [9:0]  ctx_addr;

    int n_checks = 0;
    int n_fail   = 0;

    qenc_mvd_binarizer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mvd_start    (mvd_start),
        .mvd_x        (mvd_x),
        .mvd_y        (mvd_y),
        .busy         (busy),
        .bin          (bin),
        .bin_vld      (bin_vld),
        .enc_rdy      (enc_rdy),
        .ctx_addr     (ctx_addr),
        .EPMode       (EPMode),
        .mvd_enc_done (mvd_enc_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // x, y, number of bins, number of GT1 bins, bins written first-bin-leftmost
    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        int          n;
        int          ngt1;
        logic [63:0] bits;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one MVD and follows its bin stream; stop_after>0 returns right
    // after that many transfers have been clocked.
    task automatic run_case(input vec_t v, input bit alt, input int stop_after);
        int         got;
        bit         finished;
        bit         stalled;
        logic [11:0] held;
        logic [11:0] exp;
        int          idx;
        @(negedge clk);
        mvd_x = v.x; mvd_y = v.y; mvd_start = 1'b1; enc_rdy = 1'b1;
        @(negedge clk);
        mvd_start = 1'b0;
        check("accept_busy_vld", {30'd0, busy, bin_vld}, 32'd3);
        got = 0; finished = 1'b0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (got == v.n) begin
                check("done_cycle", {29'd0, bin_vld, mvd_enc_done, busy}, 32'd3);
                @(negedge clk);
                check("back_idle", {29'd0, bin_vld, mvd_enc_done, busy}, 32'd0);
                finished = 1'b1;
            end else begin
                check("bin_vld_high", {31'd0, bin_vld}, 32'd1);
                if (stalled)
                    check("stall_hold", {20'd0, bin, EPMode, ctx_addr}, {20'd0, held});
                enc_rdy   = alt ? (cyc % 2 == 0) : 1'b1;
                mvd_start = (alt && cyc == 1);
                if (mvd_start) begin mvd_x = 16'h0000; mvd_y = 16'h0000; end
                if (enc_rdy) begin
                    idx = v.n - 1 - got;
                    if (got < 2)                 exp = {1'b0, 1'b0, 10'd40};
                    else if (got < 2 + v.ngt1)   exp = {1'b0, 1'b0, 10'd41};
                    else                         exp = {1'b0, 1'b1, 10'd0};
                    exp[11] = v.bits[idx];
                    check($sformatf("bin[%0d]", got), {20'd0, bin, EPMode, ctx_addr}, {20'd0, exp});
                    got++;
                    stalled = 1'b0;
                    if (got == stop_after) begin
                        @(posedge clk);
                        #1;
                        mvd_start = 1'b0;
                        return;
                    end
                end else begin
                    stalled = 1'b1;
                    held = {bin, EPMode, ctx_addr};
                end
            end
        end
        mvd_start = 1'b0;
        enc_rdy   = 1'b1;
        if (!finished) check("sequence_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h0000, 2, 0, 64'b00};
        vecs[1] = '{16'h0001, 16'hFFFF, 6, 2, 64'b110001};
        vecs[2] = '{16'h0005, 16'h0000, 8, 1, 64'b10110010};
        vecs[3] = '{16'h8000, 16'h0002, 38, 2,
                    64'({4'b1111, 14'h3FFF, 1'b0, 15'h0000, 1'b1, 2'b00, 1'b0})};
        vecs[4] = '{16'h0003, 16'hFFFE, 10, 2, 64'b1111010001};
        vecs[5] = '{16'h0000, 16'hFFF9, 8, 1, 64'b01110111};
        vecs[6] = '{16'h0001, 16'h0000, 4, 1, 64'b1000};
        vecs[7] = '{16'hFFFD, 16'h7FFF, 36, 2,
                    64'({4'b1111, 2'b01, 1'b1, 13'h1FFF, 1'b0, 14'h3FFF, 1'b0})};

        // Reset with a start request held: must stay idle.
        rst_n = 1'b0; mvd_start = 1'b1; mvd_x = 16'h0005; mvd_y = 16'h0000; enc_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, busy, bin, bin_vld, EPMode, mvd_enc_done, 5'd0, ctx_addr}, 32'd0);
        mvd_start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {30'd0, busy, bin_vld}, 32'd0);

        for (int i = 0; i < 8; i++) run_case(vecs[i], 1'b0, 0);

        // Alternating ready with a start request injected mid-stream.
        run_case(vecs[2], 1'b1, 0);

        // Mid-stream reset after the third transfer of the -32768 case.
        run_case(vecs[3], 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check("midstream_reset", {20'd0, busy, bin, bin_vld, EPMode, mvd_enc_done, 5'd0, ctx_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_case(vecs[0], 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
